// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op codes, FSM state type and default timing shared by muldiv_alu
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_MUL_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/muldiv_alu.sv
// rtl/muldiv_alu.sv - multi-cycle HI/LO multiply/divide unit
// Divider present only when MULDIV_ALU_DIV_EN is defined; otherwise DIV/DIVU are no-ops.
module muldiv_alu
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  // Sign- or zero-extend to 2*WIDTH so one unsigned multiplier covers MULT and MULTU.
  logic [2*WIDTH-1:0] mul_a, mul_b, product;
  logic               mul_signed;

  assign mul_signed = (op_q == OP_MULT);
  assign mul_a      = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign mul_b      = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign product    = mul_a * mul_b;

`ifdef MULDIV_ALU_DIV_EN
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows A.
  logic             div_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  assign div_signed = (op_q == OP_DIV);
  assign a_neg      = div_signed & a_q[WIDTH-1];
  assign b_neg      = div_signed & b_q[WIDTH-1];
  assign a_mag      = a_neg ? -a_q : a_q;
  assign b_mag      = b_neg ? -b_q : b_q;

  always_comb begin
    q_mag = '0;
    r_mag = '0;
    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
  end

  assign quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem  = a_neg ? -r_mag : r_mag;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d = RUN;
              cnt_d   = MUL_LOAD;
              op_d    = op;
              a_d     = A;
              b_d     = B;
            end
`ifdef MULDIV_ALU_DIV_EN
            OP_DIV, OP_DIVU: begin
              state_d = RUN;
              cnt_d   = DIV_LOAD;
              op_d    = op;
              a_d     = A;
              b_d     = B;
            end
`endif
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (is_mul_op(op_q)) begin
            hi_d = product[2*WIDTH-1:WIDTH];
            lo_d = product[WIDTH-1:0];
          end
`ifdef MULDIV_ALU_DIV_EN
          else if (b_q != '0) begin
            hi_d = rem;
            lo_d = quot;
          end
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_alu.sv
// tb/tb_muldiv_alu.sv - randomized and directed checks of muldiv_alu against an arithmetic model
// Expected DIV/DIVU behaviour follows whether MULDIV_ALU_DIV_EN is defined for the build.
module tb_muldiv_alu;

  localparam int MULC = 5;
  localparam int DIVC = 10;

  logic        clk = 1'b0;
  logic        reset, start, start16;
  logic [2:0]  op, op16;
  logic [31:0] opa, opb;
  logic [15:0] a16, b16;
  logic        busy, done, busy16, done16;
  logic [31:0] hi, lo;
  logic [15:0] hi16, lo16;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_alu #(.WIDTH(32), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(opa), .B(opb),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_alu #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output bit multi, output int lat);
    longint      p, sa, sb, q, r;
    logic [63:0] up;
    multi = 1'b0;
    lat   = 0;
    case (o)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32]; m_lo = p[31:0]; multi = 1'b1; lat = MULC;
      end
      3'd1: begin
        up = {32'b0, a} * {32'b0, b};
        m_hi = up[63:32]; m_lo = up[31:0]; multi = 1'b1; lat = MULC;
      end
`ifdef MULDIV_ALU_DIV_EN
      3'd2: begin
        multi = 1'b1; lat = DIVC;
        if (b != 0) begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      3'd3: begin
        multi = 1'b1; lat = DIVC;
        if (b != 0) begin
          m_lo = a / b; m_hi = a % b;
        end
      end
`endif
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Starts in the current cycle; returns at the negedge of the first cycle after completion.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int intr);
    bit          multi;
    int          lat;
    logic [31:0] old_hi, old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    model_op(o, a, b, multi, lat);
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0; opa = $urandom(); opb = $urandom();
    if (multi) begin
      for (int i = 1; i <= lat; i++) begin
        check("busy_run", busy, 1);
        check("done_run", done, 0);
        check("hi_hold", hi, old_hi);
        check("lo_hold", lo, old_lo);
        if (i == intr) begin
          start = 1'b1; op = 3'($urandom_range(0, 7)); opa = $urandom(); opb = $urandom();
        end
        @(negedge clk);
        start = 1'b0;
      end
      check("done_pulse", done, 1);
    end else begin
      check("done_none", done, 0);
    end
    check("busy_after", busy, 0);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  ro;
    logic [31:0] p16;
    reset = 1'b1; start = 1'b0; start16 = 1'b0;
    op = '0; op16 = '0; opa = '0; opb = '0; a16 = '0; b16 = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);

    do_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFEB);
    do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0);
    check("multu_hi_const", hi, 32'h0000_0001);
    check("multu_lo_const", lo, 32'hFFFF_FFFE);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd4, 32'h11, 32'd0, 0);
    do_op(3'd5, 32'h22, 32'd0, 0);
    do_op(3'd3, 32'h1234_5678, 32'd0, 0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'h1234, 32'd0, 0);
    check("mthi_const", hi, 32'h1234);
    do_op(3'd0, 32'd1000, 32'hFFFF_FF00, 2);
    do_op(3'd6, 32'hDEAD_BEEF, 32'd1, 0);
    do_op(3'd7, 32'hDEAD_BEEF, 32'd1, 0);

    // Reset in cycle t+3 of a DIV aborts it and clears HI/LO.
    do_op(3'd4, 32'h55, 32'd0, 0);
    do_op(3'd5, 32'h66, 32'd0, 0);
    start = 1'b1; op = 3'd2; opa = 32'd100; opb = 32'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    for (int i = 0; i < 12; i++) begin
      check("abort_no_done", done, 0);
      @(negedge clk);
    end

    // Reset wins over a same-cycle MTHI.
    reset = 1'b1; start = 1'b1; op = 3'd4; opa = 32'hABCD;
    @(negedge clk); reset = 1'b0; start = 1'b0;
    check("rst_prio_hi", hi, 0);

    for (int n = 0; n < 60; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom();
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 9);
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom();
      endcase
      do_op(ro, ra, rb, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
      end
    end

    start16 = 1'b1; op16 = 3'd1; a16 = 16'hFFFF; b16 = 16'hFFFF;
    @(negedge clk); start16 = 1'b0;
    check("w16_busy", busy16, 1);
    @(negedge clk);
    check("w16_busy_end", busy16, 0);
    check("w16_done", done16, 1);
    check("w16_hi", hi16, 16'hFFFE);
    check("w16_lo", lo16, 16'h0001);
    for (int n = 0; n < 6; n++) begin
      start16 = 1'b1; op16 = 3'd0; a16 = 16'($urandom()); b16 = 16'($urandom());
      p16 = 32'(int'($signed(a16)) * int'($signed(b16)));
      @(negedge clk); start16 = 1'b0;
      check("w16_run", busy16, 1);
      @(negedge clk);
      check("w16_mult_hi", hi16, p16[31:16]);
      check("w16_mult_lo", lo16, p16[15:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_alu.md
MULDIV_ALU -- requirements
Module: muldiv_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, which sets the operand and HI/LO width.
REQ-002 SHALL have parameter MUL_CYCLES, default 5, which sets the number of busy cycles for MULT/MULTU; legal values are 1 and above.
REQ-003 SHALL have parameter DIV_CYCLES, default 10, which sets the number of busy cycles for DIV/DIVU; legal values are 1 and above.
REQ-004 SHALL have port clk, input, width 1: the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, width 1: a one-cycle operation request.
REQ-007 SHALL have port op, input, width 3: operation code, sampled with start.
REQ-008 SHALL have port A, input, width WIDTH: operand A (dividend, or source for MTHI/MTLO).
REQ-009 SHALL have port B, input, width WIDTH: operand B (divisor).
REQ-010 SHALL have port busy, output, width 1: a multi-cycle operation is in progress.
REQ-011 SHALL have port done, output, width 1: a one-cycle pulse when HI/LO receive a multi-cycle result.
REQ-012 SHALL have ports hi and lo, output, width WIDTH each: registered HI and LO.

Function
REQ-013 SHALL decode op as follows: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 no-op.
REQ-014 SHALL accept start only when busy is 0; start while busy is 1 is ignored and SHALL leave the operation in flight untouched.
REQ-015 SHALL run a two-state FSM, IDLE and RUN, with a down-counter.
- IDLE→RUN on accepted MULT/MULTU/DIV/DIVU.
- RUN→IDLE when the counter expires.
REQ-016 SHALL latch op, A and B at acceptance edge t; busy=1 in cycles t+1 through t+LAT, where LAT is MUL_CYCLES or DIV_CYCLES.
- At the edge ending cycle t+LAT, hi/lo update and busy falls.
- In cycle t+LAT+1: busy=0, done=1, and the new hi/lo are visible.
REQ-017 SHALL accept a new start in cycle t+LAT+1, the same cycle done is high.
REQ-018 MULT/MULTU SHALL form the full 2×WIDTH product, signed or unsigned respectively; hi gets the upper WIDTH bits, lo the lower WIDTH bits.
REQ-019 DIV/DIVU SHALL write the quotient to lo and the remainder to hi.
- Signed quotient truncates toward zero; signed remainder takes the sign of A.
- Signed overflow (most-negative ÷ −1): lo=most-negative, hi=0.
REQ-020 On divide by zero (B=0), hi/lo SHALL be unchanged; busy and done SHALL behave normally.
REQ-021 MTHI/MTLO SHALL write A to hi/lo at the acceptance edge, with busy=0 and no done pulse.
REQ-022 No-op codes SHALL change no state and SHALL NOT assert busy.
REQ-023 hi/lo SHALL otherwise hold their values indefinitely.

Reset
REQ-024 When reset=1 at a clock edge: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0.
REQ-025 Reset SHALL take priority over start in the same cycle.
REQ-026 Reset during RUN SHALL abort the operation with no HI/LO update and no done pulse.

Configuration
REQ-027 With macro MULDIV_ALU_DIV_EN defined, DIV/DIVU SHALL behave per REQ-016 and REQ-019/020.
REQ-028 Without MULDIV_ALU_DIV_EN, no divider logic SHALL be synthesised; DIV/DIVU SHALL act as no-ops (REQ-022), and the DIV_CYCLES parameter is retained but unused.

Structure
REQ-029 Shared package muldiv_pkg SHALL hold the op code constants, the FSM state type (IDLE, RUN) and default cycle constants.
REQ-030 The block SHALL be a single module with no sub-module; the product and quotient are computed from latched operands and held until counter expiry.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- MULT signed (defaults): A=−3, B=7, start at t → busy in t+1..t+5; done in t+6; hi=FFFFFFFF, lo=FFFFFFEB.
- MULTU: A=FFFFFFFF, B=2 → hi=00000001, lo=FFFFFFFE after 5 busy cycles.
- DIV: A=−7, B=2 → lo=FFFFFFFD, hi=FFFFFFFF after 10 busy cycles. DIVU with B=0, prior hi=0x11, lo=0x22 → unchanged after 10 busy cycles, done pulses.
- MTHI A=0x1234 with no op in flight → hi=0x1234 next cycle, busy never set. A second start (MTLO) in cycle t+2 of a MULT is ignored; lo receives the product only.
- Reset asserted in cycle t+3 of a DIV → next cycle busy=0, hi=lo=0, and no done pulse afterwards.
- Build without MULDIV_ALU_DIV_EN: DIV start → busy stays 0, hi/lo unchanged. Build with WIDTH=16, MUL_CYCLES=1: MULTU 0xFFFF×0xFFFF → hi=0xFFFE, lo=0x0001, busy for exactly 1 cycle.
